// File: rtl/stopwatch_upcount_pkg.sv
// Shared constants, state codes and the BCD time record for the count-up stopwatch.
package stopwatch_upcount_pkg;

  localparam int                     BCD_BIT_WIDTH = 4;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO    = 4'd0;
  localparam logic [BCD_BIT_WIDTH-1:0] INCREMENT   = 4'd1;
  localparam logic                   ENABLED       = 1'b1;
  localparam logic                   DISABLED      = 1'b0;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2,
    SW_LAP   = 2'd3
  } sw_state_e;

  typedef struct packed {
    logic [BCD_BIT_WIDTH-1:0] min1;
    logic [BCD_BIT_WIDTH-1:0] min0;
    logic [BCD_BIT_WIDTH-1:0] sec1;
    logic [BCD_BIT_WIDTH-1:0] sec0;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '{BCD_ZERO, BCD_ZERO, BCD_ZERO, BCD_ZERO};

endpackage

// File: rtl/stopwatch_upcount_bcd_up_stage.sv
// One BCD up-counting digit: advances on increase, wraps at limit and flags carry.
module bcd_up_stage
  import stopwatch_upcount_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     increase,
  input  logic [BCD_BIT_WIDTH-1:0] limit,
  output logic [BCD_BIT_WIDTH-1:0] value,
  output logic                     carry
);

  logic [BCD_BIT_WIDTH-1:0] value_d;
  logic [BCD_BIT_WIDTH-1:0] value_q;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = BCD_ZERO;
    end else if (increase) begin
      value_d = (value_q == limit) ? BCD_ZERO : value_q + INCREMENT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= BCD_ZERO;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = increase && (value_q == limit);

endmodule

// File: rtl/stopwatch_upcount.sv
// Count-up MM:SS stopwatch: start/pause/lap/clear FSM, four chained BCD stages,
// sticky wrap flag and a lap snapshot that can freeze the display.
module stopwatch_upcount
  import stopwatch_upcount_pkg::*;
#(
  parameter logic [BCD_BIT_WIDTH-1:0] UNIT_LIMIT = 4'd9,
  parameter logic [BCD_BIT_WIDTH-1:0] TENS_LIMIT = 4'd5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     start_stop,
  input  logic                     lap,
  input  logic                     clear,
  output logic [BCD_BIT_WIDTH-1:0] disp_sec0,
  output logic [BCD_BIT_WIDTH-1:0] disp_sec1,
  output logic [BCD_BIT_WIDTH-1:0] disp_min0,
  output logic [BCD_BIT_WIDTH-1:0] disp_min1,
  output logic                     running,
  output logic                     lap_hold,
  output logic                     overflow
);

  sw_state_e state_d, state_q;
  bcd_time_t live;
  bcd_time_t snap_d, snap_q;
  bcd_time_t shown;
  logic      overflow_d, overflow_q;
  logic      running_q, lap_hold_q;
  logic      count_en, clear_acc, snap_load;
  logic      carry_sec0, carry_sec1, carry_min0, carry_min1;

  assign count_en  = tick && (state_q == SW_RUN || state_q == SW_LAP);
  assign clear_acc = clear && (state_q == SW_IDLE || state_q == SW_PAUSE);

  bcd_up_stage u_sec0 (.clk(clk), .rst(rst), .clear(clear_acc), .increase(count_en),
                       .limit(UNIT_LIMIT), .value(live.sec0), .carry(carry_sec0));
  bcd_up_stage u_sec1 (.clk(clk), .rst(rst), .clear(clear_acc), .increase(carry_sec0),
                       .limit(TENS_LIMIT), .value(live.sec1), .carry(carry_sec1));
  bcd_up_stage u_min0 (.clk(clk), .rst(rst), .clear(clear_acc), .increase(carry_sec1),
                       .limit(UNIT_LIMIT), .value(live.min0), .carry(carry_min0));
  bcd_up_stage u_min1 (.clk(clk), .rst(rst), .clear(clear_acc), .increase(carry_min0),
                       .limit(TENS_LIMIT), .value(live.min1), .carry(carry_min1));

  // Pulse priority is clear > start_stop > lap, resolved per state so at most one move happens.
  always_comb begin
    state_d   = state_q;
    snap_load = DISABLED;
    case (state_q)
      SW_IDLE: begin
        if (clear)           state_d = SW_IDLE;
        else if (start_stop) state_d = SW_RUN;
      end
      SW_RUN: begin
        if (start_stop) begin
          state_d = SW_PAUSE;
        end else if (lap) begin
          state_d   = SW_LAP;
          snap_load = ENABLED;
        end
      end
      SW_LAP: begin
        if (start_stop) state_d = SW_PAUSE;
        else if (lap)   state_d = SW_RUN;
      end
      SW_PAUSE: begin
        if (clear)           state_d = SW_IDLE;
        else if (start_stop) state_d = SW_RUN;
      end
      default: state_d = SW_IDLE;
    endcase

    snap_d = snap_load ? live : snap_q;

    overflow_d = overflow_q;
    if (clear_acc)       overflow_d = DISABLED;
    else if (carry_min1) overflow_d = ENABLED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SW_IDLE;
      running_q  <= DISABLED;
      lap_hold_q <= DISABLED;
      overflow_q <= DISABLED;
      snap_q     <= TIME_ZERO;
    end else begin
      state_q    <= state_d;
      running_q  <= (state_d == SW_RUN) || (state_d == SW_LAP);
      lap_hold_q <= (state_d == SW_LAP);
      overflow_q <= overflow_d;
      snap_q     <= snap_d;
    end
  end

  assign shown     = lap_hold_q ? snap_q : live;
  assign disp_sec0 = shown.sec0;
  assign disp_sec1 = shown.sec1;
  assign disp_min0 = shown.min0;
  assign disp_min1 = shown.min1;
  assign running   = running_q;
  assign lap_hold  = lap_hold_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_upcount.sv
// Directed bench for stopwatch_upcount: a seconds-based reference model feeds a
// scoreboard queue that is checked one cycle after every stimulus step.
module tb_stopwatch_upcount;

  typedef struct packed {
    logic [15:0] disp;
    logic        running;
    logic        lap_hold;
    logic        overflow;
  } exp_t;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] disp_sec0, disp_sec1, disp_min0, disp_min1;
  logic       running, lap_hold, overflow;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  int   mCnt  = 0;
  int   mSnap = 0;
  int   mSt   = M_IDLE;
  bit   mOvf  = 1'b0;

  stopwatch_upcount dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp_sec0(disp_sec0), .disp_sec1(disp_sec1), .disp_min0(disp_min0), .disp_min1(disp_min1),
    .running(running), .lap_hold(lap_hold), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Reference behaviour written in whole seconds rather than digit stages.
  task automatic modelStep(input bit tk, input bit ss, input bit lp, input bit cl);
    int  nSt;
    bit  countEn;
    nSt     = mSt;
    countEn = tk && (mSt == M_RUN || mSt == M_LAP);
    if ((mSt == M_IDLE || mSt == M_PAUSE) && cl) begin
      nSt  = M_IDLE;
      mCnt = 0;
      mOvf = 1'b0;
    end else begin
      case (mSt)
        M_IDLE:  if (ss) nSt = M_RUN;
        M_PAUSE: if (ss) nSt = M_RUN;
        M_RUN: begin
          if (ss) nSt = M_PAUSE;
          else if (lp) begin
            nSt   = M_LAP;
            mSnap = mCnt;
          end
        end
        default: begin
          if (ss) nSt = M_PAUSE;
          else if (lp) nSt = M_RUN;
        end
      endcase
      if (countEn) begin
        if (mCnt == 3599) begin
          mCnt = 0;
          mOvf = 1'b1;
        end else begin
          mCnt = mCnt + 1;
        end
      end
    end
    mSt = nSt;
  endtask

  function automatic exp_t modelOut();
    exp_t e;
    e.running  = (mSt == M_RUN || mSt == M_LAP);
    e.lap_hold = (mSt == M_LAP);
    e.overflow = mOvf;
    e.disp     = (mSt == M_LAP) ? toBcd(mSnap) : toBcd(mCnt);
    return e;
  endfunction

  task automatic compareField(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = expQ.pop_front();
      compareField({tag, "_disp"}, {disp_min1, disp_min0, disp_sec1, disp_sec0}, e.disp);
      compareField({tag, "_running"}, {15'd0, running}, {15'd0, e.running});
      compareField({tag, "_lap_hold"}, {15'd0, lap_hold}, {15'd0, e.lap_hold});
      compareField({tag, "_overflow"}, {15'd0, overflow}, {15'd0, e.overflow});
    end
  endtask

  task automatic checkConst(input string tag, input logic [15:0] d, input logic r,
                            input logic l, input logic o);
    compareField({tag, "_disp"}, {disp_min1, disp_min0, disp_sec1, disp_sec0}, d);
    compareField({tag, "_running"}, {15'd0, running}, {15'd0, r});
    compareField({tag, "_lap_hold"}, {15'd0, lap_hold}, {15'd0, l});
    compareField({tag, "_overflow"}, {15'd0, overflow}, {15'd0, o});
  endtask

  task automatic applyStimulus(input string tag, input bit tk, input bit ss,
                               input bit lp, input bit cl);
    @(negedge clk);
    tick = tk; start_stop = ss; lap = lp; clear = cl;
    modelStep(tk, ss, lp, cl);
    expQ.push_back(modelOut());
    @(posedge clk);
    #1;
    tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    checkOutput(tag);
  endtask

  task automatic runTicks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #12;
    checkConst("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Start and count 75 seconds.
    applyStimulus("t1_start", 1'b0, 1'b1, 1'b0, 1'b0);
    runTicks("t1_ticks", 75);
    checkConst("t1_0115", 16'h0115, 1'b1, 1'b0, 1'b0);

    // Reach 59:59, wrap, keep counting, then clear from PAUSE.
    runTicks("t2_ticks", 3599 - 75);
    checkConst("t2_5959", 16'h5959, 1'b1, 1'b0, 1'b0);
    applyStimulus("t2_wrap", 1'b1, 1'b0, 1'b0, 1'b0);
    checkConst("t2_0000", 16'h0000, 1'b1, 1'b0, 1'b1);
    applyStimulus("t2_after", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("t2_pause", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("t2_clear", 1'b0, 1'b0, 1'b0, 1'b1);
    checkConst("t2_cleared", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Lap entry coincident with a tick freezes the pre-increment value.
    applyStimulus("t3_start", 1'b0, 1'b1, 1'b0, 1'b0);
    runTicks("t3_ticks", 12);
    applyStimulus("t3_lap", 1'b1, 1'b0, 1'b1, 1'b0);
    checkConst("t3_frozen", 16'h0012, 1'b1, 1'b1, 1'b0);
    runTicks("t3_more", 7);
    checkConst("t3_still", 16'h0012, 1'b1, 1'b1, 1'b0);
    applyStimulus("t3_release", 1'b0, 1'b0, 1'b1, 1'b0);
    checkConst("t3_0020", 16'h0020, 1'b1, 1'b0, 1'b0);

    // start_stop with tick at 00:09 counts, then pauses; clear beats start_stop.
    applyStimulus("t4_pause", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_clear", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("t4_start", 1'b0, 1'b1, 1'b0, 1'b0);
    runTicks("t4_ticks", 9);
    applyStimulus("t4_stoptick", 1'b1, 1'b1, 1'b0, 1'b0);
    checkConst("t4_0010", 16'h0010, 1'b0, 1'b0, 1'b0);
    runTicks("t4_paused", 3);
    checkConst("t4_hold", 16'h0010, 1'b0, 1'b0, 1'b0);
    applyStimulus("t4_clrss", 1'b0, 1'b1, 1'b0, 1'b1);
    checkConst("t4_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

    // clear is ignored while running; start_stop beats lap; lap ignored in PAUSE.
    applyStimulus("t5_start", 1'b0, 1'b1, 1'b0, 1'b0);
    runTicks("t5_ticks", 30);
    applyStimulus("t5_clear", 1'b0, 1'b0, 1'b0, 1'b1);
    checkConst("t5_0030", 16'h0030, 1'b1, 1'b0, 1'b0);
    applyStimulus("t5_tick", 1'b1, 1'b0, 1'b0, 1'b0);
    checkConst("t5_0031", 16'h0031, 1'b1, 1'b0, 1'b0);
    applyStimulus("t5_sslap", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("t5_lapidle", 1'b1, 1'b0, 1'b1, 1'b0);
    checkConst("t5_paused", 16'h0031, 1'b0, 1'b0, 1'b0);
    applyStimulus("t5_resume", 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in LAP at 02:40.
    runTicks("t6_ticks", 129);
    applyStimulus("t6_lap", 1'b0, 1'b0, 1'b1, 1'b0);
    checkConst("t6_lap", 16'h0240, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkConst("t6_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    mCnt = 0; mSnap = 0; mSt = M_IDLE; mOvf = 1'b0;
    expQ.delete();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("t6_idle_tick", 1'b1, 1'b0, 1'b0, 1'b0);
    checkConst("t6_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
